// File: rtl/rate_limit_sched.sv
`default_nettype none
// rate_limit_sched: token-bucket packet release scheduler with a small register file (rev 1.0).
// Define RATE_LIMIT_SCHED_STATS_EN to add the GRANT_CNT (5) / STALL_CNT (6) read-only counters.
module rate_limit_sched #(
  parameter int CPCI_NF2_DATA_WIDTH = 32,
  parameter int TOKEN_WIDTH         = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           pkt_req,
  input  logic [8:0]                     pkt_len,
  output logic                           pkt_grant,
  input  logic                           pkt_eop,
  input  logic                           reg_req,
  input  logic                           reg_rd_wr_L,
  input  logic [2:0]                     reg_addr,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_wr_data,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_rd_data,
  output logic                           reg_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, WAIT_EOP = 2'd2} state_t;

  state_t                         state_q, state_d;
  logic                           grant_q, grant_d;
  logic                           req_prev_q, req_prev_d;
  logic                           ack_q, ack_d;
  logic [CPCI_NF2_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                           enable_q, enable_d;
  logic [TOKEN_WIDTH-1:0]         rate_inc_q, rate_inc_d;
  logic [TOKEN_WIDTH-1:0]         bucket_max_q, bucket_max_d;
  logic [TOKEN_WIDTH-1:0]         tokens_q, tokens_d;
  logic [3:0]                     shift_q, shift_d;
  logic [15:0]                    tick_cnt_q, tick_cnt_d;

  logic                           reg_start;
  logic                           tick;
  logic                           grant_now;
  logic [8:0]                     eff_len;
  logic [TOKEN_WIDTH:0]           eff_len_x;
  logic [TOKEN_WIDTH:0]           sum;
  logic                           unused_wr_bits;

  assign reg_start      = reg_req && !req_prev_q;
  assign eff_len        = (pkt_len == 9'd0) ? 9'd1 : pkt_len;
  assign eff_len_x      = {{(TOKEN_WIDTH-8){1'b0}}, eff_len};
  assign tick           = (tick_cnt_q == ((16'd1 << shift_q) - 16'd1));
  assign unused_wr_bits = ^reg_wr_data[CPCI_NF2_DATA_WIDTH-1:TOKEN_WIDTH];

  always_comb begin
    state_d   = state_q;
    grant_d   = 1'b0;
    grant_now = 1'b0;
    case (state_q)
      IDLE:     if (pkt_req) state_d = CHECK;
      CHECK: begin
        if (!pkt_req) begin
          state_d = IDLE;
        end else if (!enable_q || ({1'b0, tokens_q} >= eff_len_x)) begin
          grant_now = 1'b1;
          grant_d   = 1'b1;
          state_d   = WAIT_EOP;
        end
      end
      WAIT_EOP: if (pkt_eop) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Refill and debit share one adder; the clamp uses the pre-write BUCKET_MAX,
  // so a lowered maximum takes hold on the cycle after the write lands.
  always_comb begin
    sum = {1'b0, tokens_q};
    if (tick) sum = sum + {1'b0, rate_inc_q};
    if (grant_now && enable_q) sum = sum - eff_len_x;
    tokens_d = (sum > {1'b0, bucket_max_q}) ? bucket_max_q : sum[TOKEN_WIDTH-1:0];
  end

`ifdef RATE_LIMIT_SCHED_STATS_EN
  logic [31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (grant_now && (grant_cnt_q != '1)) grant_cnt_d = grant_cnt_q + 32'd1;
    if ((state_q == CHECK) && !grant_now && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

  always_comb begin
    req_prev_d   = reg_req;
    ack_d        = reg_start;
    rd_data_d    = '0;
    enable_d     = enable_q;
    rate_inc_d   = rate_inc_q;
    shift_d      = shift_q;
    bucket_max_d = bucket_max_q;
    tick_cnt_d   = tick ? 16'd0 : tick_cnt_q + 16'd1;
    if (reg_start && reg_rd_wr_L) begin
      case (reg_addr)
        3'd0:    rd_data_d[0]               = enable_q;
        3'd1:    rd_data_d[TOKEN_WIDTH-1:0] = rate_inc_q;
        3'd2:    rd_data_d[3:0]             = shift_q;
        3'd3:    rd_data_d[TOKEN_WIDTH-1:0] = bucket_max_q;
        3'd4:    rd_data_d[TOKEN_WIDTH-1:0] = tokens_q;
`ifdef RATE_LIMIT_SCHED_STATS_EN
        3'd5:    rd_data_d[31:0]            = grant_cnt_q;
        3'd6:    rd_data_d[31:0]            = stall_cnt_q;
`endif
        default: rd_data_d = '0;
      endcase
    end
    if (reg_start && !reg_rd_wr_L) begin
      case (reg_addr)
        3'd0: enable_d     = reg_wr_data[0];
        3'd1: rate_inc_d   = reg_wr_data[TOKEN_WIDTH-1:0];
        3'd2: begin
          shift_d    = reg_wr_data[3:0];
          tick_cnt_d = 16'd0;
        end
        3'd3: bucket_max_d = reg_wr_data[TOKEN_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      req_prev_q   <= 1'b0;
      ack_q        <= 1'b0;
      rd_data_q    <= '0;
      enable_q     <= 1'b0;
      rate_inc_q   <= '0;
      shift_q      <= '0;
      bucket_max_q <= '1;
      tokens_q     <= '0;
      tick_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      req_prev_q   <= req_prev_d;
      ack_q        <= ack_d;
      rd_data_q    <= rd_data_d;
      enable_q     <= enable_d;
      rate_inc_q   <= rate_inc_d;
      shift_q      <= shift_d;
      bucket_max_q <= bucket_max_d;
      tokens_q     <= tokens_d;
      tick_cnt_q   <= tick_cnt_d;
    end
  end

  assign pkt_grant   = grant_q;
  assign reg_ack     = ack_q;
  assign reg_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_rate_limit_sched.sv
`default_nettype none
// tb_rate_limit_sched: register table, directed corner sequences and random traffic vs a token-bucket model.
module tb_rate_limit_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pkt_req, pkt_eop, pkt_grant;
  logic [8:0]  pkt_len;
  logic        reg_req, reg_rd_wr_L, reg_ack;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wr_data, reg_rd_data;

  int checks = 0;
  int failures = 0;

  rate_limit_sched #(.CPCI_NF2_DATA_WIDTH(32), .TOKEN_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .pkt_req(pkt_req), .pkt_len(pkt_len),
    .pkt_grant(pkt_grant), .pkt_eop(pkt_eop), .reg_req(reg_req),
    .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_data(reg_rd_data), .reg_ack(reg_ack)
  );

  always #5 clk = ~clk;

  // Reference model: token bucket held as plain integers.
  int          m_tokens, m_rate, m_shift, m_bmax, m_phase;
  bit          m_enable, m_waiting, m_in_pkt, m_prev_req;
  bit          m_grant, m_ack;
  logic [31:0] m_rd, m_gcnt, m_scnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tokens = 0; m_rate = 0; m_shift = 0; m_bmax = 65535; m_phase = 0;
    m_enable = 0; m_waiting = 0; m_in_pkt = 0; m_prev_req = 0;
    m_grant = 0; m_ack = 0; m_rd = 0; m_gcnt = 0; m_scnt = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {31'd0, m_enable};
      3'd1: return 32'(m_rate);
      3'd2: return 32'(m_shift);
      3'd3: return 32'(m_bmax);
      3'd4: return 32'(m_tokens);
`ifdef RATE_LIMIT_SCHED_STATS_EN
      3'd5: return m_gcnt;
      3'd6: return m_scnt;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int  period, eff, nt;
    bit  tick, grant, start;
    period = 1 << m_shift;
    tick   = ((m_phase + 1) % period) == 0;
    eff    = (pkt_len == 9'd0) ? 1 : int'(pkt_len);
    grant  = m_waiting && pkt_req && (!m_enable || m_tokens >= eff);
    nt     = m_tokens + (tick ? m_rate : 0) - ((grant && m_enable) ? eff : 0);
    if (nt > m_bmax) nt = m_bmax;
    if (grant && m_gcnt != 32'hFFFF_FFFF) m_gcnt++;
    if (m_waiting && !grant && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    start   = reg_req && !m_prev_req;
    m_ack   = start;
    m_rd    = (start && reg_rd_wr_L) ? m_read(reg_addr) : 32'd0;
    m_phase = tick ? 0 : m_phase + 1;
    m_tokens = nt;
    if (start && !reg_rd_wr_L) begin
      case (reg_addr)
        3'd0: m_enable = reg_wr_data[0];
        3'd1: m_rate   = int'(reg_wr_data[15:0]);
        3'd2: begin m_shift = int'(reg_wr_data[3:0]); m_phase = 0; end
        3'd3: m_bmax   = int'(reg_wr_data[15:0]);
        default: ;
      endcase
    end
    if (m_waiting) begin
      m_waiting = pkt_req && !grant;
      m_in_pkt  = grant;
    end else if (m_in_pkt) begin
      if (pkt_eop) m_in_pkt = 0;
    end else begin
      m_waiting = pkt_req;
    end
    m_grant    = grant;
    m_prev_req = reg_req;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("grant", {31'd0, pkt_grant}, {31'd0, m_grant});
    chk("ack", {31'd0, reg_ack}, {31'd0, m_ack});
    chk("rd_data", reg_rd_data, m_rd);
  endtask

  task automatic apply_reset();
    reset_n = 0; pkt_req = 0; pkt_eop = 0; pkt_len = 0;
    reg_req = 0; reg_rd_wr_L = 1; reg_addr = 0; reg_wr_data = 0;
    model_reset();
    #1;
    chk("rst_grant", {31'd0, pkt_grant}, 32'd0);
    chk("rst_ack", {31'd0, reg_ack}, 32'd0);
    chk("rst_rd_data", reg_rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic reg_op(input logic rdwr, input logic [2:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    reg_req = 1; reg_rd_wr_L = rdwr; reg_addr = addr; reg_wr_data = wd;
    step();
    rd = reg_rd_data;
    chk("reg_ack_high", {31'd0, reg_ack}, 32'd1);
    reg_req = 0;
    step();
    chk("reg_ack_low", {31'd0, reg_ack}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    reg_op(1'b0, addr, wd, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    reg_op(1'b1, addr, 32'd0, v);
    chk(name, v, exp);
  endtask

  task automatic end_pkt();
    pkt_req = 0; pkt_eop = 1;
    step();
    pkt_eop = 0;
    step();
  endtask

  typedef struct {
    logic        rdwr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n;
    logic [31:0] v;

    tbl[0]  = '{1'b1, 3'd0, 32'h0,        32'h0};
    tbl[1]  = '{1'b1, 3'd1, 32'h0,        32'h0};
    tbl[2]  = '{1'b1, 3'd2, 32'h0,        32'h0};
    tbl[3]  = '{1'b1, 3'd3, 32'h0,        32'h0000_FFFF};
    tbl[4]  = '{1'b1, 3'd4, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 3'd5, 32'h0,        32'h0};
    tbl[6]  = '{1'b1, 3'd6, 32'h0,        32'h0};
    tbl[7]  = '{1'b1, 3'd7, 32'h0,        32'h0};
    tbl[8]  = '{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{1'b1, 3'd0, 32'h0,        32'h1};
    tbl[10] = '{1'b0, 3'd2, 32'h0000_001F, 32'h0};
    tbl[11] = '{1'b1, 3'd2, 32'h0,        32'hF};
    tbl[12] = '{1'b0, 3'd3, 32'hABCD_1234, 32'h0};
    tbl[13] = '{1'b1, 3'd3, 32'h0,        32'h1234};
    tbl[14] = '{1'b0, 3'd7, 32'h55,       32'h0};
    tbl[15] = '{1'b0, 3'd4, 32'h77,       32'h0};

    apply_reset();
    for (int i = 0; i < 16; i++) begin
      reg_op(tbl[i].rdwr, tbl[i].addr, tbl[i].wdata, v);
      chk($sformatf("tbl%0d", i), v, tbl[i].exp);
    end
    rd_chk("tokens_ro", 3'd4, 32'h0);
    rd_chk("addr7_ro", 3'd7, 32'h0);

    // ENABLE=0 grants on the second clock and never debits
    apply_reset();
    pkt_req = 1; pkt_len = 9'd10;
    step(); chk("req027_c1", {31'd0, pkt_grant}, 32'd0);
    step(); chk("req027_c2", {31'd0, pkt_grant}, 32'd1);
    pkt_req = 0;
    step(); chk("req027_single", {31'd0, pkt_grant}, 32'd0);
    rd_chk("req027_tokens", 3'd4, 32'd0);
    end_pkt();

    // pkt_req withdrawn while stalled: no grant, no debit
    wr(3'd0, 32'd1);
    pkt_req = 1; pkt_len = 9'd5;
    repeat (3) step();
    pkt_req = 0;
    repeat (2) step();
    chk("req023_nogrant", {31'd0, pkt_grant}, 32'd0);
    rd_chk("req023_tokens", 3'd4, 32'd0);

    // Grant waits for tokens to reach the packet length
    apply_reset();
    wr(3'd0, 32'd1);
    wr(3'd3, 32'd100);
    pkt_req = 1; pkt_len = 9'd20;
    step(); step();
    wr(3'd1, 32'd4);
    n = 0;
    while (!pkt_grant && n < 40) begin step(); n++; end
    chk("req028_latency", 32'(n), 32'd5);
    pkt_req = 0;
    rd_chk("req028_tokens", 3'd4, 32'd4);
    end_pkt();

    // Saturation at BUCKET_MAX, clamp on lowered max, no wrap at full width
    apply_reset();
    wr(3'd3, 32'd100);
    wr(3'd1, 32'd8);
    repeat (20) step();
    rd_chk("req029_sat", 3'd4, 32'd100);
    wr(3'd3, 32'd50);
    rd_chk("req029_clamp", 3'd4, 32'd50);
    wr(3'd3, 32'hFFFF);
    wr(3'd1, 32'hFFFF);
    repeat (3) step();
    rd_chk("no_wrap", 3'd4, 32'hFFFF);

    // Tick coincident with debit
    apply_reset();
    wr(3'd3, 32'd30);
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd30);
    wr(3'd1, 32'd5);
    pkt_req = 1; pkt_len = 9'd30;
    step(); step();
    chk("req030_grant", {31'd0, pkt_grant}, 32'd1);
    pkt_req = 0;
    rd_chk("req030_tokens", 3'd4, 32'd5);
    end_pkt();

    // pkt_len=0 costs one token
    apply_reset();
    wr(3'd2, 32'd2);
    wr(3'd0, 32'd1);
    pkt_req = 1; pkt_len = 9'd0;
    step();
    wr(3'd1, 32'd1);
    n = 0;
    while (!pkt_grant && n < 20) begin step(); n++; end
    chk("req031_granted", {31'd0, pkt_grant}, 32'd1);
    chk("req031_bound", {31'd0, (n <= 5)}, 32'd1);
    pkt_req = 0;
    rd_chk("req031_tokens", 3'd4, 32'd0);
    end_pkt();

    // Asynchronous reset during WAIT_EOP
    apply_reset();
    wr(3'd3, 32'd77);
    wr(3'd1, 32'd3);
    pkt_req = 1; pkt_len = 9'd10;
    step(); step();
    chk("req032_grant", {31'd0, pkt_grant}, 32'd1);
    #2;
    apply_reset();
    pkt_eop = 1; step(); pkt_eop = 0; step();
    chk("req032_eop_ignored", {31'd0, pkt_grant}, 32'd0);
    rd_chk("req032_rate", 3'd1, 32'd0);
    rd_chk("req032_bmax", 3'd3, 32'hFFFF);
    rd_chk("req032_tokens", 3'd4, 32'd0);
    rd_chk("req032_gcnt", 3'd5, 32'd0);
    rd_chk("req032_scnt", 3'd6, 32'd0);
    pkt_req = 1; pkt_len = 9'd3;
    step(); chk("req032_post_c1", {31'd0, pkt_grant}, 32'd0);
    step(); chk("req032_post_c2", {31'd0, pkt_grant}, 32'd1);
    end_pkt();

    // Random traffic and register accesses against the model
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) pkt_req = ~pkt_req;
      if ($urandom_range(0, 3) == 0) pkt_len = 9'($urandom_range(0, 40));
      pkt_eop = ($urandom_range(0, 7) == 0);
      if (reg_req) begin
        if ($urandom_range(0, 1) == 0) reg_req = 0;
      end else if ($urandom_range(0, 4) == 0) begin
        reg_req     = 1;
        reg_rd_wr_L = $urandom_range(0, 1) == 1;
        reg_addr    = 3'($urandom_range(0, 7));
        case (reg_addr)
          3'd1:    reg_wr_data = $urandom_range(0, 12);
          3'd2:    reg_wr_data = $urandom_range(0, 3);
          3'd3:    reg_wr_data = $urandom_range(0, 200);
          default: reg_wr_data = $urandom;
        endcase
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rate_limit_sched.md
RATE_LIMIT_SCHED -- requirements
Module: rate_limit_sched

Interface
REQ-001 Parameter CPCI_NF2_DATA_WIDTH, default 32, register data width.
REQ-002 Parameter TOKEN_WIDTH, default 16, token counter and bucket width.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 pkt_req  input  1  head-of-line packet waiting in the upstream queue.
REQ-006 pkt_len  input  9  packet length in 64-bit words; valid while pkt_req is high.
REQ-007 pkt_grant  output  1  one-cycle pulse that releases one packet to the rate limiter datapath.
REQ-008 pkt_eop  input  1  one-cycle pulse marking the last word of the granted packet.
REQ-009 reg_req, reg_rd_wr_L, reg_addr[2:0], reg_wr_data[CPCI_NF2_DATA_WIDTH-1:0]  inputs  register access: request, 1=read/0=write, address, write data.
REQ-010 reg_rd_data[CPCI_NF2_DATA_WIDTH-1:0], reg_ack  outputs  register read data and one-cycle acknowledge.

Function
REQ-011 Registers: 0 ENABLE[0]; 1 RATE_INC[TOKEN_WIDTH-1:0]; 2 SHIFT[3:0]; 3 BUCKET_MAX[TOKEN_WIDTH-1:0]; 4 TOKENS (read-only); other addresses read 0 and ignore writes.
REQ-012 reg_ack SHALL pulse for exactly one cycle, one cycle after a reg_req rising edge; reg_rd_data SHALL be valid in the ack cycle; a write SHALL take effect in the ack cycle.
REQ-013 A tick counter SHALL emit a refill tick every 2^SHIFT cycles; a SHIFT write SHALL restart the tick counter at 0.
REQ-014 On a tick, TOKENS SHALL become min(BUCKET_MAX, TOKENS+RATE_INC), computed at TOKEN_WIDTH+1 bits with no wrap-around.
REQ-015 FSM states: IDLE, CHECK, WAIT_EOP. IDLE->CHECK when pkt_req=1. CHECK->WAIT_EOP with pkt_grant=1 when ENABLE=0 or TOKENS>=eff_len. CHECK stays in CHECK otherwise. WAIT_EOP->IDLE on pkt_eop.
REQ-016 eff_len SHALL be pkt_len, except that pkt_len=0 SHALL be treated as 1.
REQ-017 When a grant occurs with ENABLE=1, eff_len SHALL be debited in the same cycle. When ENABLE=0, no debit SHALL occur.
REQ-018 If a tick coincides with a debit, the result SHALL be min(BUCKET_MAX, TOKENS+RATE_INC-eff_len).
REQ-019 Grant-to-CHECK latency: pkt_grant SHALL assert on the second clock after pkt_req rises if tokens suffice; at most one grant per packet.
REQ-020 pkt_eop received in IDLE or CHECK SHALL be ignored.
REQ-021 Writing BUCKET_MAX below the current TOKENS SHALL clamp TOKENS to the new BUCKET_MAX on the following cycle.
REQ-022 Clearing ENABLE while in WAIT_EOP SHALL NOT abort the packet; the new setting SHALL apply from the next CHECK.
REQ-023 If pkt_req drops while in CHECK, the FSM SHALL return to IDLE with no grant and no debit.

Reset
REQ-024 While reset_n=0: FSM=IDLE, pkt_grant=0, reg_ack=0, reg_rd_data=0, ENABLE=0, RATE_INC=0, SHIFT=0, BUCKET_MAX=all ones, TOKENS=0, tick counter=0.
REQ-025 Reset asserted mid-packet SHALL return the FSM to IDLE immediately; no grant SHALL be issued until reset_n has been high for one full clock.

Configuration
REQ-026 Macro RATE_LIMIT_SCHED_STATS_EN: when defined, adds read-only register 5 GRANT_CNT (32-bit count of grants) and register 6 STALL_CNT (32-bit count of cycles spent in CHECK without a grant), both cleared by reset and saturating at all ones. When undefined, addresses 5 and 6 read 0 and the counters are absent.

Verification
REQ-027 ENABLE=0, pkt_req with pkt_len=10 -> pkt_grant 2 cycles later; TOKENS remains 0.
REQ-028 ENABLE=1, RATE_INC=4, SHIFT=0, BUCKET_MAX=100, pkt_len=20 from TOKENS=0 -> grant on the cycle TOKENS first reaches >=20; TOKENS then drops by 20.
REQ-029 TOKENS=96, BUCKET_MAX=100, RATE_INC=8, tick with no grant -> TOKENS=100 (saturates, no wrap); then write BUCKET_MAX=50 -> TOKENS=50 next cycle.
REQ-030 Tick coincident with a grant: TOKENS=30, RATE_INC=5, pkt_len=30 -> TOKENS=5 after that cycle.
REQ-031 pkt_len=0 with TOKENS=0, RATE_INC=1, SHIFT=2 -> grant after first tick; TOKENS returns to 0.
REQ-032 reset_n pulsed low during WAIT_EOP -> all outputs and registers at reset values; a later pkt_eop is ignored; STALL_CNT/GRANT_CNT=0 with RATE_LIMIT_SCHED_STATS_EN defined.
